// File: rtl/rd_arbiter.sv
// Two-master (IFU/LSU) to one-slave read-channel arbiter with a single outstanding
// transaction, round-robin or fixed-priority grant, and a response timeout that fabricates SLVERR.
module rd_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_ARVALID,
    output logic          ifu_ARREADY,
    input  logic [AW-1:0] ifu_ARADDR,
    input  logic [2:0]    ifu_ARPORT,
    output logic          ifu_RVALID,
    input  logic          ifu_RREADY,
    output logic [DW-1:0] ifu_RDATA,
    output logic [1:0]    ifu_RRESP,

    input  logic          lsu_ARVALID,
    output logic          lsu_ARREADY,
    input  logic [AW-1:0] lsu_ARADDR,
    input  logic [2:0]    lsu_ARPORT,
    output logic          lsu_RVALID,
    input  logic          lsu_RREADY,
    output logic [DW-1:0] lsu_RDATA,
    output logic [1:0]    lsu_RRESP,

    output logic          mem_ARVALID,
    input  logic          mem_ARREADY,
    output logic [AW-1:0] mem_ARADDR,
    output logic [2:0]    mem_ARPORT,
    input  logic          mem_RVALID,
    output logic          mem_RREADY,
    input  logic [DW-1:0] mem_RDATA,
    input  logic [1:0]    mem_RRESP,

    output logic          busy,
    output logic [7:0]    drop_cnt,
    output logic [1:0]    dbg_state
);

    // Handshake rule on every channel: a transfer happens on a rising edge where VALID and
    // READY are both high; a source holds VALID and its payload stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam bit FIXED_PRIO = (PRIO_MODE != 0);
    localparam bit TMO_EN     = (TIMEOUT != 0);
    localparam int CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t          state_q, state_d;
    logic            owner_q;
    logic            last_grant_q;
    logic [AW-1:0]   addr_q;
    logic [2:0]      port_q;
    logic [CW-1:0]   tmo_q;
    logic [7:0]      drop_q;

    logic            req_any;
    logic            pick_lsu;
    logic            grant;
    logic            owner_rready;
    logic            tmo_expire;
    logic            stale_beat;

    // ------------------------------------------------------------------
    // Arbitration: on a tie, round-robin favours whoever did not win last.
    // ------------------------------------------------------------------
    always_comb begin
        req_any  = ifu_ARVALID | lsu_ARVALID;
        pick_lsu = lsu_ARVALID &
                   (~ifu_ARVALID | FIXED_PRIO | (last_grant_q == M_IFU));
        grant    = (state_q == S_IDLE) & req_any;
    end

    always_comb begin
        owner_rready = (owner_q == M_LSU) ? lsu_RREADY : ifu_RREADY;
        // A beat arriving in the expiry cycle wins over the timeout.
        tmo_expire   = TMO_EN & (state_q == S_DATA) & ~mem_RVALID & (tmo_q == TMO_LAST);
        stale_beat   = mem_RVALID & (state_q != S_DATA);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (mem_ARREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (mem_RVALID && owner_rready) state_d = S_IDLE;
                else if (tmo_expire)            state_d = S_ERR;
            end
            S_ERR: begin
                if (owner_rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ifu_ARREADY = 1'b0;
        lsu_ARREADY = 1'b0;
        ifu_RVALID  = 1'b0;
        ifu_RDATA   = '0;
        ifu_RRESP   = 2'b00;
        lsu_RVALID  = 1'b0;
        lsu_RDATA   = '0;
        lsu_RRESP   = 2'b00;
        mem_ARVALID = 1'b0;
        mem_RREADY  = 1'b1;
        case (state_q)
            S_IDLE: begin
                ifu_ARREADY = req_any & ~pick_lsu;
                lsu_ARREADY = pick_lsu;
            end
            S_ADDR: begin
                mem_ARVALID = 1'b1;
            end
            S_DATA: begin
                mem_RREADY = owner_rready;
                if (owner_q == M_LSU) begin
                    lsu_RVALID = mem_RVALID;
                    lsu_RDATA  = mem_RDATA;
                    lsu_RRESP  = mem_RRESP;
                end else begin
                    ifu_RVALID = mem_RVALID;
                    ifu_RDATA  = mem_RDATA;
                    ifu_RRESP  = mem_RRESP;
                end
            end
            S_ERR: begin
                if (owner_q == M_LSU) begin
                    lsu_RVALID = 1'b1;
                    lsu_RRESP  = RESP_SLVERR;
                end else begin
                    ifu_RVALID = 1'b1;
                    ifu_RRESP  = RESP_SLVERR;
                end
            end
            default: begin
                mem_RREADY = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, owner tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            port_q       <= '0;
            owner_q      <= M_IFU;
            last_grant_q <= M_IFU;
        end else if (grant) begin
            addr_q       <= pick_lsu ? lsu_ARADDR : ifu_ARADDR;
            port_q       <= pick_lsu ? lsu_ARPORT : ifu_ARPORT;
            owner_q      <= pick_lsu;
            last_grant_q <= pick_lsu;
        end
    end

    // ------------------------------------------------------------------
    // Response timeout counter: restarts on every accepted address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_q == S_ADDR && mem_ARREADY) begin
            tmo_q <= '0;
        end else if (state_q == S_DATA && !mem_RVALID) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stale beat counter: any R beat not belonging to a live DATA phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (stale_beat && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign mem_ARADDR = addr_q;
    assign mem_ARPORT = port_q;
    assign busy       = (state_q != S_IDLE);
    assign drop_cnt   = drop_q;
    assign dbg_state  = state_q;

    // ------------------------------------------------------------------
    // Interface properties
    // ------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        !(ifu_ARREADY && lsu_ARREADY));

    a_ar_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_ARVALID && !mem_ARREADY) |=> (mem_ARVALID && $stable(mem_ARADDR) && $stable(mem_ARPORT)));

    a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(ifu_RVALID && lsu_RVALID));

endmodule

// File: doc/rd_arbiter.md
Name: rd_arbiter

Overview:
- Two-master, one-slave read-channel arbiter. Shares the single memory read port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU read interfaces and the memory/bus read interface.
- Exactly one transaction is outstanding at a time: AR handshake, then one R beat.
- Includes a response timeout that synthesises an error response, so a hung slave cannot lock the CPU.

Parameters:
- AW, 64, address width.
- DW, 64, read data width.
- PRIO_MODE, 0, 0 = round-robin on simultaneous requests; 1 = fixed priority, LSU wins.
- TIMEOUT, 255, cycles to wait for mem_RVALID after the AR handshake; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- ifu_ARVALID  in  1  IFU read request.
- ifu_ARREADY  out  1  IFU request accepted.
- ifu_ARADDR  in  AW  IFU address.
- ifu_ARPORT  in  3  IFU protection bits.
- ifu_RVALID  out  1  IFU response valid.
- ifu_RREADY  in  1  IFU response accept.
- ifu_RDATA  out  DW  IFU read data.
- ifu_RRESP  out  2  IFU response code.
- lsu_ARVALID, lsu_ARREADY, lsu_ARADDR, lsu_ARPORT, lsu_RVALID, lsu_RREADY, lsu_RDATA, lsu_RRESP: same directions, widths and meanings for the LSU.
- mem_ARVALID  out  1  request to memory.
- mem_ARREADY  in  1  memory accepts request.
- mem_ARADDR  out  AW  latched address.
- mem_ARPORT  out  3  latched protection bits.
- mem_RVALID  in  1  memory response valid.
- mem_RREADY  out  1  response accept.
- mem_RDATA  in  DW  memory read data.
- mem_RRESP  in  2  memory response code.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  8  saturating count of stale memory R beats discarded.

Behaviour:
- States: IDLE, ADDR, DATA, ERR.
- Reset (rst=1 at posedge):
  - State goes to IDLE; last_grant = IFU; owner = IFU; latched addr/port = 0; timeout counter = 0; drop_cnt = 0.
  - All outputs then read as 0, except mem_RREADY = 1 (IDLE drain behaviour).
  - Reset mid-transaction abandons the transaction without any response to the master.
- IDLE:
  - If any *_ARVALID is high, select a winner:
    - Single requester wins.
    - Both requesting with PRIO_MODE=0: the master not equal to last_grant wins.
    - Both requesting with PRIO_MODE=1: LSU wins.
  - Winner's *_ARREADY is asserted combinationally in the same cycle. Loser's ARREADY stays 0; loser must hold its request (AXI rule).
  - Next edge: latch ADDR/PORT, set owner and last_grant to the winner, go to ADDR.
  - mem_RREADY = 1. Any mem_RVALID beat here is stale: discard it and increment drop_cnt, saturating at 255.
- ADDR:
  - mem_ARVALID = 1 with the latched address/port, held stable until mem_ARREADY.
  - On mem_ARREADY: clear the timeout counter, go to DATA.
  - No master ARREADY is asserted in this state. mem_RREADY = 1 with stale-beat drop as in IDLE.
- DATA:
  - owner_RVALID = mem_RVALID, owner_RDATA = mem_RDATA, owner_RRESP = mem_RRESP, mem_RREADY = owner_RREADY.
  - Non-owner RVALID = 0, RDATA = 0, RRESP = 0.
  - On the mem_RVALID & owner_RREADY handshake: go to IDLE. The earliest next grant is the following cycle, so a full transaction takes 3 cycles minimum (IDLE accept, ADDR, DATA).
  - With TIMEOUT != 0, the counter increments every DATA cycle without mem_RVALID. When it reaches TIMEOUT with mem_RVALID still low, go to ERR.
  - mem_RVALID in the same cycle as expiry takes precedence: the normal response is forwarded.
- ERR:
  - owner_RVALID = 1, RDATA = 0, RRESP = 2'b10 (SLVERR), held until owner_RREADY, then go to IDLE.
  - mem_RREADY = 1; a late slave beat is dropped and counted.
- Response-path outputs (RVALID/RDATA/RRESP) are combinational from state and mem inputs. The AR path to memory is registered.
- busy = (state != IDLE).

Test Plan:
- Single IFU read: ifu_ARVALID with addr 0x8000_0000; mem_ARREADY=1; mem returns data 0xDEAD_BEEF with resp 00 two cycles later -> ifu_ARREADY pulses 1 cycle, mem_ARADDR = 0x8000_0000, ifu_RDATA = 0xDEAD_BEEF, lsu_RVALID stays 0, busy low after the handshake.
- Simultaneous requests, PRIO_MODE=0, both held for 4 transactions -> grants alternate LSU, IFU, LSU, IFU (last_grant resets to IFU, so LSU goes first).
- Simultaneous requests, PRIO_MODE=1 -> LSU is granted every time while it keeps requesting; IFU is granted only when lsu_ARVALID is low.
- Backpressure: mem_ARREADY held 0 for 5 cycles -> mem_ARVALID and mem_ARADDR stable all 5 cycles. Then owner_RREADY=0 for 3 cycles with mem_RVALID=1 -> mem_RREADY=0 and data held; completes when RREADY=1.
- Timeout with TIMEOUT=4, no mem_RVALID -> after 4 DATA cycles the owner sees RVALID=1, RRESP=2'b10, RDATA=0. A mem_RVALID 2 cycles later, while in IDLE, -> drop_cnt = 1 and no master RVALID.
- Reset asserted while in DATA -> next cycle: state IDLE, busy = 0, all RVALID = 0, drop_cnt = 0, mem_RREADY = 1.
